// File: rtl/uart_tx_serializer_pkg.sv
// Shared encodings for the serial link: transmitter FSM states and line levels.
// The receiver on the far end imports the same constants.
package uart_tx_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer_bit_timer.sv
// Reloadable modulo-CLKS_PER_BIT counter; bit_tick marks the last cycle of each bit period.
module uart_bit_timer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic restart,
    output logic bit_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Decoded from the registered count, so with CLKS_PER_BIT=1 it is high every cycle.
    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits LSB first, stop bit.
// TX_SERIAL and TX_DONE are registered; READY/BUSY decode the registered state.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              TX_VALID,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic              TX_READY,
    output logic              TX_SERIAL,
    output logic              TX_BUSY,
    output logic              TX_DONE
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state, state_nx;
    logic [DATA_W-1:0] shift, shift_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic              serial_nx;
    logic              done_nx;
    logic              accept;
    logic              bit_tick;

    assign accept   = TX_VALID && (state == IDLE);
    assign TX_READY = (state == IDLE);
    assign TX_BUSY  = (state != IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_bit_timer (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .restart (accept),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            shift     <= '0;
            idx       <= '0;
            TX_SERIAL <= LINE_IDLE;
            TX_DONE   <= 1'b0;
        end else begin
            state     <= state_nx;
            shift     <= shift_nx;
            idx       <= idx_nx;
            TX_SERIAL <= serial_nx;
            TX_DONE   <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        shift_nx = shift;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = START;
                    shift_nx = TX_DATA;
                    idx_nx   = '0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_nx = DATA;
                    idx_nx   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx == LAST_IDX) begin
                        state_nx = STOP;
                    end else begin
                        shift_nx = shift >> 1;
                        idx_nx   = idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Line level is computed from the upcoming state so the registered output aligns with it.
    always_comb begin
        serial_nx = LINE_IDLE;
        done_nx   = (state == STOP) && bit_tick;
        case (state_nx)
            START:   serial_nx = START_BIT;
            DATA:    serial_nx = shift_nx[0];
            STOP:    serial_nx = STOP_BIT;
            default: serial_nx = LINE_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three parameterisations (8/4, 8/1, 1/2) driven from one thread.
module tb_uart_tx_serializer;

    logic CLK   = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    logic [7:0] data_a = '0, data_b = '0;
    logic [0:0] data_c = '0;
    logic ready_a, serial_a, busy_a, done_a;
    logic ready_b, serial_b, busy_b, done_b;
    logic ready_c, serial_c, busy_c, done_c;

    uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .CNT_W(16)) dut_a (
        .CLK(CLK), .RST_n(RST_n), .TX_VALID(valid_a), .TX_DATA(data_a),
        .TX_READY(ready_a), .TX_SERIAL(serial_a), .TX_BUSY(busy_a), .TX_DONE(done_a));

    uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(1), .CNT_W(16)) dut_b (
        .CLK(CLK), .RST_n(RST_n), .TX_VALID(valid_b), .TX_DATA(data_b),
        .TX_READY(ready_b), .TX_SERIAL(serial_b), .TX_BUSY(busy_b), .TX_DONE(done_b));

    uart_tx_serializer #(.DATA_W(1), .CLKS_PER_BIT(2), .CNT_W(16)) dut_c (
        .CLK(CLK), .RST_n(RST_n), .TX_VALID(valid_c), .TX_DATA(data_c),
        .TX_READY(ready_c), .TX_SERIAL(serial_c), .TX_BUSY(busy_c), .TX_DONE(done_c));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   sel   = 0;
    logic exp_q[$];
    logic ser_m, rdy_m, busy_m, done_m;

    always_comb begin
        ser_m = serial_a; rdy_m = ready_a; busy_m = busy_a; done_m = done_a;
        case (sel)
            1: begin ser_m = serial_b; rdy_m = ready_b; busy_m = busy_b; done_m = done_b; end
            2: begin ser_m = serial_c; rdy_m = ready_c; busy_m = busy_c; done_m = done_c; end
            default: ;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        case (s)
            1:       begin valid_b = v; data_b = d; end
            2:       begin valid_c = v; data_c = d[0]; end
            default: begin valid_a = v; data_a = d; end
        endcase
    endtask

    // exp holds the frame bits in line order, first bit at position len-1.
    task automatic run_frame(input int s, input logic [7:0] d, input logic [11:0] exp,
                             input int nbits, input int cpb, input bit hold,
                             input logic [7:0] nd, input bit immediate, input string nm);
        int   w;
        int   len;
        logic e;
        sel = s;
        len = nbits + 2;
        w   = 0;
        @(negedge CLK);
        drive(s, 1'b1, d);
        while (!rdy_m && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (!rdy_m) begin
            check($sformatf("%s accept timeout", nm), 0, 1);
            drive(s, 1'b0, d);
            return;
        end
        if (immediate) check($sformatf("%s gap after done", nm), w, 0);
        for (int i = 0; i < len; i++)
            for (int c = 0; c < cpb; c++)
                exp_q.push_back(exp[len-1-i]);
        @(posedge CLK);
        #1;
        if (hold) drive(s, 1'b1, nd);
        else      drive(s, 1'b0, d);
        for (int i = 0; i < len * cpb; i++) begin
            if (i > 0) begin
                @(posedge CLK);
                #1;
            end
            e = exp_q.pop_front();
            check($sformatf("%s serial[%0d]", nm, i), ser_m, e);
            check($sformatf("%s busy[%0d]", nm, i), busy_m, 1);
            check($sformatf("%s done[%0d]", nm, i), done_m, 0);
        end
        @(posedge CLK);
        #1;
        check($sformatf("%s done pulse", nm), done_m, 1);
        check($sformatf("%s ready at done", nm), rdy_m, 1);
        check($sformatf("%s busy at done", nm), busy_m, 0);
        check($sformatf("%s line idle at done", nm), ser_m, 1);
        check($sformatf("%s queue drained", nm), exp_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [11:0] exp;
        bit          hold;
        logic [7:0]  nd;
        bit          imm;
        string       nm;
    } vec_t;

    vec_t tbl[4];
    bit   seen_done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA5, 12'b0101001011, 1'b0, 8'h00, 1'b0, "a5"};
        tbl[1] = '{8'h3C, 12'b0001111001, 1'b1, 8'hFF, 1'b0, "3c_hold"};
        tbl[2] = '{8'hFF, 12'b0111111111, 1'b0, 8'h00, 1'b1, "ff_b2b"};
        tbl[3] = '{8'h01, 12'b0100000001, 1'b0, 8'h00, 1'b0, "01"};

        // Reset held with VALID high: no frame may start.
        RST_n   = 1'b0;
        valid_a = 1'b1;
        data_a  = 8'hC3;
        repeat (3) @(posedge CLK);
        #1;
        check("rst serial_a", serial_a, 1);
        check("rst ready_a", ready_a, 1);
        check("rst busy_a", busy_a, 0);
        check("rst done_a", done_a, 0);
        check("rst serial_b", serial_b, 1);
        check("rst serial_c", serial_c, 1);
        @(negedge CLK);
        valid_a = 1'b0;
        RST_n   = 1'b1;
        @(posedge CLK);
        #1;
        check("post-rst busy_a", busy_a, 0);
        check("post-rst serial_a", serial_a, 1);

        for (int t = 0; t < 4; t++)
            run_frame(0, tbl[t].d, tbl[t].exp, 8, 4, tbl[t].hold, tbl[t].nd, tbl[t].imm, tbl[t].nm);

        run_frame(1, 8'h01, 12'b0100000001, 8, 1, 1'b0, 8'h00, 1'b0, "cpb1_01");
        run_frame(2, 8'h00, 12'b000000000001, 1, 2, 1'b0, 8'h00, 1'b0, "w1_0");

        // Mid-frame reset during data bit 3 of 0x00.
        sel = 0;
        @(negedge CLK);
        drive(0, 1'b1, 8'h00);
        @(posedge CLK);
        #1;
        drive(0, 1'b0, 8'h00);
        check("midrst start bit", serial_a, 0);
        repeat (17) @(posedge CLK);
        #1;
        check("midrst data bit3", serial_a, 0);
        check("midrst busy before", busy_a, 1);
        #1;
        RST_n = 1'b0;
        #1;
        check("midrst serial async", serial_a, 1);
        check("midrst busy async", busy_a, 0);
        check("midrst ready async", ready_a, 1);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(posedge CLK);
            #1;
            if (done_a) seen_done = 1'b1;
        end
        check("midrst no done", seen_done, 0);
        check("midrst ready after", ready_a, 1);
        run_frame(0, 8'h55, 12'b0101010101, 8, 4, 1'b0, 8'h00, 1'b0, "after_rst_55");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Parallel-in, serial-out frame transmitter, the transmit end of the team's serial link.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Emits the word on a single line as an asynchronous-serial frame: start bit 0, data LSB first, stop bit 1.
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between a register/FIFO source and the pad-level TX line; pairs with the serial receiver on the far end.

Parameters:
DATA_W, 8, data bits per frame; legal range 1..16.
CLKS_PER_BIT, 4, CLK cycles per serial bit; legal range 1..65535.
CNT_W, 16, width of bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
CLK  input  1  system clock, rising-edge active.
RST_n  input  1  reset, asynchronous, active-low.
TX_VALID  input  1  source has a word on TX_DATA.
TX_DATA  input  DATA_W  word to send; sampled only on the accept edge.
TX_READY  output  1  block can accept a word; high only in IDLE.
TX_SERIAL  output  1  serial line; idle level 1; registered.
TX_BUSY  output  1  frame in progress (START, DATA or STOP state).
TX_DONE  output  1  one-cycle pulse on frame completion; registered.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, TX_SERIAL=1, TX_BUSY=0, TX_DONE=0, TX_READY=1.
  - Bit counter, bit index and shift register clear to 0.
- Reset mid-frame: TX_SERIAL returns to 1 immediately (async). The frame is abandoned and never resumed. No TX_DONE is issued.
- Accept: edge k where TX_VALID=1 and TX_READY=1.
  - TX_DATA is latched into the shift register.
  - state goes to START and TX_SERIAL=0 from edge k.
  - Later changes on TX_DATA do not affect the frame in flight.
- TX_VALID while TX_READY=0 is ignored. No queuing; the source must hold VALID.
- States:
  - IDLE: TX_SERIAL=1. On accept go to START.
  - START: TX_SERIAL=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX_SERIAL = shift[0]. Each CLKS_PER_BIT cycles, shift right and increment the index. After bit DATA_W-1 has been held its full period, go to STOP.
  - STOP: TX_SERIAL=1 for CLKS_PER_BIT cycles, then go to IDLE with TX_DONE=1 for exactly one cycle.
- Bit-period counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Reset to 0 on accept.
  - With CLKS_PER_BIT=1 every bit lasts one cycle.
- Timing:
  - Frame occupies edges k..k+(DATA_W+2)*CLKS_PER_BIT.
  - The DONE edge is k+(DATA_W+2)*CLKS_PER_BIT; TX_READY=1 in the cycle after it.
  - The earliest next accept is the DONE edge +1, so back-to-back frames have 1 idle-high cycle between them.
- TX_BUSY = (state != IDLE). TX_READY = (state == IDLE). Both are decoded from registered state.
- TX_DONE and TX_READY are high together in the cycle after completion. An accept in that cycle is legal.
- The bit index wraps only through a frame restart; no other wrap-around exists.
- Unreachable state encodings recover to IDLE with TX_SERIAL=1.

Decomposition:
- Shared header/package:
  - State encodings: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Line levels: LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - The receiver uses the same constants.
- One natural sub-module, uart_bit_timer:
  - Reloadable modulo-CLKS_PER_BIT counter.
  - Inputs: CLK, RST_n, restart. Output: one-cycle bit_tick at period end.
  - The transmitter FSM advances only on bit_tick.

Test Plan:
- Reset check: hold RST_n=0 for 3 cycles with TX_VALID=1 -> TX_SERIAL=1, TX_READY=1, TX_BUSY=0, TX_DONE=0; no accept happens during reset.
- Single frame: DATA_W=8, CLKS_PER_BIT=4, send 0xA5 at edge k.
  - TX_SERIAL sequence, 4 cycles each: 0 | 1,0,1,0,0,1,0,1 | 1.
  - TX_DONE=1 only in the cycle after edge k+40; TX_BUSY=1 over edges k..k+39.
- Data stability: change TX_DATA to 0xFF and hold TX_VALID=1 during the 0x3C frame -> line carries 0x3C bits (0,0,1,1,1,1,0,0 LSB first). A second frame carrying 0xFF starts exactly 1 cycle after TX_DONE.
- Minimum period: CLKS_PER_BIT=1, DATA_W=8, send 0x01 -> line 0,1,0,0,0,0,0,0,0,1 on 10 consecutive cycles; TX_DONE at edge k+10.
- Mid-frame reset: assert RST_n=0 during data bit 3 of 0x00 -> TX_SERIAL=1 within the same cycle, no TX_DONE pulse. After release, TX_READY=1 and a new 0x55 frame transmits correctly.
- Boundary width: DATA_W=1, CLKS_PER_BIT=2, send 1'b0 -> line 0,0,0,0,1,1; TX_DONE at edge k+6.
